msb_first_serial_comparator: RTL
================================

// Module: msb_first_serial_comparator
// PURPOSE
//  Sequential magnitude comparator for wide operands. It scans one CHUNK_W-bit slice per cycle
//  from the MSB chunk down to the LSB chunk and terminates early at the first unequal chunk.
//  This is the reverse of the LSB-to-MSB cascade chain, so wide compares use one small chunk
//  comparator instead of a full combinational chain. Cascade inputs resolve the all-equal case,
//  so the block can act as the low stage of a larger compare.
// PARAMETERS
//  CHUNK_W     4   bits compared per cycle (>=1)
//  NUM_CHUNKS  8   chunks per operand (>=1); operand width W = CHUNK_W*NUM_CHUNKS
//  IDX_W       derived, not overridable: max(1,$clog2(NUM_CHUNKS))
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-high reset
//  in_valid     in   1      request valid
//  in_ready     out  1      block can accept a request (high only in IDLE)
//  a            in   W      operand A, sampled on accept
//  b            in   W      operand B, sampled on accept
//  Iagtb        in   1      cascade gt, result if all chunks equal; sampled on accept
//  Iaeqb        in   1      cascade eq, result if all chunks equal; sampled on accept
//  Ialtb        in   1      cascade lt, result if all chunks equal; sampled on accept
//  out_valid    out  1      result valid; held until out_ready
//  out_ready    in   1      consumer accepts result
//  Oagtb        out  1      registered a>b result
//  Oaeqb        out  1      registered a==b result
//  Oaltb        out  1      registered a<b result
//  diff_idx     out  IDX_W  index of first unequal chunk (NUM_CHUNKS-1 = MSB); 0 if all equal
// BEHAVIOUR
//  Reset (rst=1 at edge), from any state: state=IDLE; in_ready=1; out_valid=0; Oagtb/Oaeqb/Oaltb=0;
//   diff_idx=0; latched operands discarded. Mid-scan or mid-hold requests are dropped, never output.
//  FSM IDLE -> SCAN -> DONE -> IDLE:
//   IDLE: in_ready=1. On in_valid: latch a, b and cascade inputs; idx=NUM_CHUNKS-1; go to SCAN.
//   SCAN: in_ready=0. Compare a[idx*CHUNK_W +: CHUNK_W] with the same slice of b, unsigned.
//    >  : Oagtb=1, Oaeqb=0, Oaltb=0; diff_idx=idx; go to DONE.
//    <  : Oaltb=1, Oagtb=0, Oaeqb=0; diff_idx=idx; go to DONE.
//    == and idx==0 : {Oagtb,Oaeqb,Oaltb} = latched {Iagtb,Iaeqb,Ialtb}, passed through unmodified
//       (illegal combinations included); diff_idx=0; go to DONE.
//    == and idx>0 : idx=idx-1; stay in SCAN.
//   DONE: out_valid=1; outputs stable. On out_ready: next state IDLE, out_valid=0.
//    Result outputs keep their values until the next result is written or reset.
//  Latency: accept at edge E0; k = chunks examined (1..NUM_CHUNKS); out_valid high from edge E0+k.
//   Best case: out_valid 1 cycle after accept. Worst case: NUM_CHUNKS cycles.
//  in_ready=0 during SCAN and DONE; in_valid is ignored there. in_valid in the same cycle as
//   out_ready in DONE is not accepted; the next accept is earliest in the following IDLE cycle.
//  Operand/cascade input changes after accept have no effect on the result.
//  NUM_CHUNKS=1: single SCAN cycle; result is either the chunk compare or the cascade inputs.
//  Unsigned arithmetic only; no signed mode.
// TESTING (CHUNK_W=4, NUM_CHUNKS=8)
//  1 Reset: hold rst 2 cycles -> in_ready=1, out_valid=0, O*=0, diff_idx=0.
//  2 Early exit: a=32'h8000_0000, b=32'h7FFF_FFFF -> Oagtb=1, diff_idx=7, out_valid 1 cycle after accept.
//  3 Late exit: a=32'h0000_0010, b=32'h0000_0011 -> Oaltb=1, diff_idx=0, out_valid 8 cycles after accept.
//  4 Equal case: a=b=32'h1234_5678 with cascade {gt,eq,lt}=010 -> Oaeqb=1 after 8 cycles.
//    Repeat with cascade 100 -> Oagtb=1.
//  5 Backpressure: out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0,
//    in_valid pulse ignored. Then out_ready=1 -> IDLE next cycle.
//  6 Reset mid-op: rst at 3rd SCAN cycle -> next cycle IDLE, out_valid never asserts for that request.

Source files
------------

// File: rtl/msb_first_serial_comparator_if.sv
// Request/response bundle for msb_first_serial_comparator.
//   master : request source and result consumer (drives operands, cascade
//            inputs, in_valid and out_ready).
//   slave  : the comparator (drives in_ready, out_valid and the results).
// Signals:
//   in_valid/in_ready     request handshake
//   a, b                  operands, W = CHUNK_W*NUM_CHUNKS bits, unsigned
//   Iagtb/Iaeqb/Ialtb     cascade result used when every chunk is equal
//   out_valid/out_ready   result handshake
//   Oagtb/Oaeqb/Oaltb     registered compare result
//   diff_idx              index of the first unequal chunk (0 if all equal)
interface msb_first_serial_comparator_if #(
  parameter int CHUNK_W    = 4,
  parameter int NUM_CHUNKS = 8
);
  localparam int W     = CHUNK_W * NUM_CHUNKS;
  localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             Iagtb;
  logic             Iaeqb;
  logic             Ialtb;
  logic             out_valid;
  logic             out_ready;
  logic             Oagtb;
  logic             Oaeqb;
  logic             Oaltb;
  logic [IDX_W-1:0] diff_idx;

  modport master (
    output in_valid, a, b, Iagtb, Iaeqb, Ialtb, out_ready,
    input  in_ready, out_valid, Oagtb, Oaeqb, Oaltb, diff_idx
  );

  modport slave (
    input  in_valid, a, b, Iagtb, Iaeqb, Ialtb, out_ready,
    output in_ready, out_valid, Oagtb, Oaeqb, Oaltb, diff_idx
  );
endinterface

// File: rtl/msb_first_serial_comparator.sv
// Sequential unsigned magnitude comparator for wide operands.
// One CHUNK_W-bit slice is compared per cycle, starting at the MSB chunk and
// stopping at the first unequal chunk. If every chunk is equal the latched
// cascade inputs become the result, so the block can serve as the low stage
// of a larger compare.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  slave side of msb_first_serial_comparator_if (request/response)
module msb_first_serial_comparator #(
  parameter int CHUNK_W    = 4,
  parameter int NUM_CHUNKS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  msb_first_serial_comparator_if.slave  bus
);

  localparam int W     = CHUNK_W * NUM_CHUNKS;
  localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  state_e           state_q,    state_d;
  logic [W-1:0]     a_q,        a_d;
  logic [W-1:0]     b_q,        b_d;
  logic [2:0]       casc_q,     casc_d;     // {gt, eq, lt}
  logic [IDX_W-1:0] idx_q,      idx_d;
  logic [2:0]       res_q,      res_d;      // {gt, eq, lt}
  logic [IDX_W-1:0] diff_idx_q, diff_idx_d;

  logic [CHUNK_W-1:0] chunk_a;
  logic [CHUNK_W-1:0] chunk_b;

  // Select the chunk addressed by idx_q from the latched operands.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        chunk_a = a_q[i*CHUNK_W +: CHUNK_W];
        chunk_b = b_q[i*CHUNK_W +: CHUNK_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    casc_d     = casc_q;
    idx_d      = idx_q;
    res_d      = res_q;
    diff_idx_d = diff_idx_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          casc_d  = {bus.Iagtb, bus.Iaeqb, bus.Ialtb};
          idx_d   = MSB_IDX;
          state_d = SCAN;
        end
      end

      SCAN: begin
        if (chunk_a > chunk_b) begin
          res_d      = 3'b100;
          diff_idx_d = idx_q;
          state_d    = DONE;
        end else if (chunk_a < chunk_b) begin
          res_d      = 3'b001;
          diff_idx_d = idx_q;
          state_d    = DONE;
        end else if (idx_q == '0) begin
          // All chunks equal: cascade inputs pass through untouched, even
          // illegal combinations.
          res_d      = casc_q;
          diff_idx_d = '0;
          state_d    = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      casc_q     <= '0;
      idx_q      <= '0;
      res_q      <= '0;
      diff_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      casc_q     <= casc_d;
      idx_q      <= idx_d;
      res_q      <= res_d;
      diff_idx_q <= diff_idx_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Oagtb     = res_q[2];
  assign bus.Oaeqb     = res_q[1];
  assign bus.Oaltb     = res_q[0];
  assign bus.diff_idx  = diff_idx_q;

endmodule
